fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of a FIFO (full flag, write strobe, write data) between NUM_REQ producers.
- Each producer uses a valid/ready handshake and may send bursts of up to MAX_BURST beats, delimited by a last flag.
- Grants are registered, so FIFO write data and strobe always come from a stable, registered selection.
- Sits between producer blocks and the fifo write interface; the arbiter never writes when the FIFO is full.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, width of each beat and of the FIFO write data.
- MAX_BURST, 8, maximum beats per grant before forced release (1..256).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- arst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  per-requester last-beat-of-burst flag, qualified by valid.
- req_ready  output  NUM_REQ  per-requester ready; only the granted bit can be 1.
- fifo_full  input  1  FIFO full flag.
- fifo_wr  output  1  FIFO write strobe.
- fifo_wr_data  output  DATA_WIDTH  FIFO write data.
- grant_valid  output  1  a requester currently holds the grant.
- grant_id  output  $clog2(NUM_REQ)  index of the granted requester; 0 when no grant is held.

Behaviour:
- The FSM has two states: IDLE and GRANT. Registers are state, grant_id, last_grant and beat_cnt (width $clog2(MAX_BURST+1)).
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, grant_id=0, last_grant=NUM_REQ-1, beat_cnt=0.
  - All outputs are 0.
- IDLE:
  - If any req_valid bit is 1, select the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register that index into grant_id, set beat_cnt=0, and move to GRANT on the next edge.
  - If no req_valid bit is set, stay in IDLE.
  - All outputs are 0 in IDLE.
- Arbitration latency: a request that arrives in IDLE gets its first possible write one cycle later.
- GRANT, with g=grant_id:
  - grant_valid=1.
  - req_ready[g] = !fifo_full; every other req_ready bit is 0.
  - fifo_wr = req_valid[g] & !fifo_full.
  - fifo_wr_data = req_data[g] when in GRANT, otherwise 0.
  - All three are combinational from registered state plus the inputs.
- Beat definition: a beat transfers in a cycle where req_valid[g] & req_ready[g] is 1. Each beat increments beat_cnt.
- Release: the FSM returns to IDLE on the next edge, with last_grant<=g and grant_id<=0, in any of these cases:
  - (a) a beat transfers with req_last[g]=1.
  - (b) a beat transfers and beat_cnt==MAX_BURST-1, i.e. the MAX_BURST-th beat (forced split).
  - (c) req_valid[g]=0 in a GRANT cycle (idle release, prevents lockup).
- Full handling: while fifo_full=1 in GRANT:
  - fifo_wr=0 and req_ready[g]=0.
  - No beat transfers, beat_cnt holds, and there is no release.
  - Release by (c) still applies if valid drops.
- Release to regrant: there is exactly one IDLE bubble cycle between consecutive grants.
- Round-robin fairness:
  - The releasing requester has the lowest priority in the next arbitration.
  - A lone requester can be regranted after the bubble.
- Other requesters' valid/data/last are ignored while not granted. Those requesters must hold their data stable until they see ready.
- Reset mid-burst: the partial burst is abandoned and no fifo_wr occurs during reset. After reset, requester 0 has highest priority.
- The FIFO never sees fifo_wr=1 while fifo_full=1.

Test Plan:
- Bench parameters for all scenarios: NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4.
- Reset, then req_valid=4'b0100, req_data[2]=0xA5, req_last[2]=1 for one beat:
  - cycle 1 is IDLE with all outputs 0.
  - cycle 2 has grant_id=2, fifo_wr=1, fifo_wr_data=0xA5, req_ready=4'b0100.
  - cycle 3 is IDLE.
- All 4 requesters valid continuously with last=0:
  - grants are 0,1,2,3,0 in that order, each with exactly 4 fifo_wr pulses, and one bubble cycle (fifo_wr=0) between grants.
- Requester 1 granted, fifo_full=1 for 3 cycles after its 2nd beat:
  - fifo_wr=0 and req_ready=0 during those cycles, with no release.
  - After full clears, exactly 2 more beats are written, then release.
- Requester 0 drops valid after 2 beats while requester 3 is valid:
  - requester 0 is released after 2 writes.
  - the next grant_id is 3 and requester 0 goes to lowest priority.
- arst_n pulsed low during beat 3 of requester 2's burst:
  - fifo_wr, req_ready, grant_valid and fifo_wr_data go to 0 immediately.
  - after release with all 4 requesters valid, the first grant is 0.
- Only requester 3 valid, 10 beats with last=0:
  - bursts of 4, 4 and 2 beats, with one bubble between bursts.
  - grant_id=3 each time and 10 total fifo_wr pulses.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares one FIFO write port between NUM_REQ
// producers. Each producer drives beats with a valid/ready handshake and marks
// the end of a burst with req_last. One requester at a time holds a registered
// grant. The grant ends on a last beat, on the MAX_BURST-th beat, or when the
// granted requester drops valid. Consecutive grants are always separated by
// one idle cycle, and the FIFO is never written while it reports full.
//
// Ports:
//   clk          clock, rising edge
//   arst_n       asynchronous active-low reset
//   req_valid    per-requester beat valid
//   req_data     packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     per-requester last-beat flag (qualified by valid)
//   req_ready    per-requester ready; only the granted bit can be set
//   fifo_full    FIFO full flag
//   fifo_wr      FIFO write strobe
//   fifo_wr_data FIFO write data (0 when no grant is held)
//   grant_valid  a requester currently holds the grant
//   grant_id     index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q,      state_d;
    logic [ID_W-1:0]   grant_id_q,   grant_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  beat_cnt_q,   beat_cnt_d;

    // Unpack the beat bus so the granted beat can be selected by index.
    logic [DATA_WIDTH-1:0] beat_data [NUM_REQ];

    logic in_grant;
    logic granted_valid;
    logic granted_last;
    logic beat_xfer;

    // Round-robin pick
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic [ID_W-1:0] cand;

    assign in_grant      = (state_q == GRANT);
    assign granted_valid = req_valid[grant_id_q];
    assign granted_last  = req_last[grant_id_q];
    assign beat_xfer     = in_grant && granted_valid && !fifo_full;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign beat_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign req_ready[gi] = in_grant && !fifo_full && (grant_id_q == ID_W'(gi));
    end

    assign grant_valid  = in_grant;
    assign grant_id     = grant_id_q;
    assign fifo_wr      = beat_xfer;
    assign fifo_wr_data = in_grant ? beat_data[grant_id_q] : '0;

    // Search starts just after the last released requester, so the releasing
    // requester is checked last. The index wraps explicitly because NUM_REQ
    // need not be a power of two.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = (last_grant_q == LAST_ID) ? '0 : last_grant_q + 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
            cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                // Dropping valid releases the grant even while full, so a
                // stalled producer cannot lock the port.
                if (!granted_valid ||
                    (beat_xfer && (granted_last || beat_cnt_q == BURST_END))) begin
                    state_d      = IDLE;
                    last_grant_d = grant_id_q;
                    grant_id_d   = '0;
                    beat_cnt_d   = '0;
                end else if (beat_xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= LAST_ID;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter with NUM_REQ=4, DATA_WIDTH=8,
// MAX_BURST=4. Inputs change 1 time unit after the rising edge and outputs
// are sampled on the falling edge. Expected values are hand-derived per cycle.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_wr_data;
    logic        grant_valid;
    logic [1:0]  grant_id;

    int compared   = 0;
    int mismatched = 0;
    int wr_cnt     = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_wr_data (fifo_wr_data),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    // One line per FIFO write transaction.
    always @(negedge clk) begin
        if (fifo_wr)
            $display("t=%0t write gid=%0d data=%02h", $time, grant_id, fifo_wr_data);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic gv, input logic [1:0] gid,
                           input logic wr, input logic [7:0] data, input logic [3:0] rdy);
        chk({tag, " grant_valid"}, 32'(grant_valid), 32'(gv));
        chk({tag, " grant_id"},    32'(grant_id),    32'(gid));
        chk({tag, " fifo_wr"},     32'(fifo_wr),     32'(wr));
        chk({tag, " wr_data"},     32'(fifo_wr_data), 32'(data));
        chk({tag, " req_ready"},   32'(req_ready),   32'(rdy));
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        cyc();
        arst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        arst_n    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;

        // ---- Reset state ----
        #2;
        chk_out("reset", 0, 0, 0, 8'h00, 4'b0000);
        cyc();
        cyc();
        arst_n = 1'b1;

        // ---- S1: single-beat burst from requester 2 ----
        req_valid = 4'b0100;
        req_data[23:16] = 8'hA5;
        req_last  = 4'b0100;
        smp(); chk_out("s1 c1", 0, 0, 0, 8'h00, 4'b0000); cyc();
        smp(); chk_out("s1 c2", 1, 2, 1, 8'hA5, 4'b0100); cyc();
        req_valid = '0;
        req_last  = '0;
        smp(); chk_out("s1 c3", 0, 0, 0, 8'h00, 4'b0000); cyc();

        // ---- S2: all four valid, bursts split at MAX_BURST ----
        do_reset();
        req_valid = 4'b1111;
        req_last  = '0;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 25; k++) begin
            smp();
            if (k % 5 == 0) begin
                chk_out($sformatf("s2 k=%0d", k), 0, 0, 0, 8'h00, 4'b0000);
            end else begin
                int id;
                id = (k / 5) % 4;
                chk_out($sformatf("s2 k=%0d", k), 1, 2'(id), 1, 8'(8'h10 + id), 4'(1 << id));
            end
            cyc();
        end
        req_valid = '0;
        smp(); chk_out("s2 end", 0, 0, 0, 8'h00, 4'b0000); cyc();

        // ---- S3: requester 1 stalled by fifo_full after two beats ----
        req_valid = 4'b0010;
        req_data[15:8] = 8'h21;
        smp(); chk_out("s3 idle", 0, 0, 0, 8'h00, 4'b0000); cyc();
        smp(); chk_out("s3 b1",   1, 1, 1, 8'h21, 4'b0010); cyc();
        smp(); chk_out("s3 b2",   1, 1, 1, 8'h21, 4'b0010); cyc();
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp(); chk_out($sformatf("s3 full%0d", k), 1, 1, 0, 8'h21, 4'b0000); cyc();
        end
        fifo_full = 1'b0;
        smp(); chk_out("s3 b3",   1, 1, 1, 8'h21, 4'b0010); cyc();
        smp(); chk_out("s3 b4",   1, 1, 1, 8'h21, 4'b0010); cyc();
        req_valid = '0;
        smp(); chk_out("s3 rel",  0, 0, 0, 8'h00, 4'b0000); cyc();

        // ---- S4: requester 0 drops valid after 2 beats, 3 waiting ----
        do_reset();
        req_valid = 4'b1001;
        req_data  = {8'h43, 8'h00, 8'h00, 8'h40};
        req_last  = '0;
        smp(); chk_out("s4 idle", 0, 0, 0, 8'h00, 4'b0000); cyc();
        smp(); chk_out("s4 b1",   1, 0, 1, 8'h40, 4'b0001); cyc();
        smp(); chk_out("s4 b2",   1, 0, 1, 8'h40, 4'b0001); cyc();
        req_valid = 4'b1000;
        smp(); chk_out("s4 drop", 1, 0, 0, 8'h40, 4'b0001); cyc();
        req_valid = 4'b1001;
        smp(); chk_out("s4 bub",  0, 0, 0, 8'h00, 4'b0000); cyc();
        req_last  = 4'b1000;
        smp(); chk_out("s4 g3",   1, 3, 1, 8'h43, 4'b1000); cyc();
        req_last  = '0;
        smp(); chk_out("s4 bub2", 0, 0, 0, 8'h00, 4'b0000); cyc();
        req_valid = '0;
        smp(); chk_out("s4 g0",   1, 0, 0, 8'h40, 4'b0001); cyc();
        smp(); chk_out("s4 end",  0, 0, 0, 8'h00, 4'b0000); cyc();

        // ---- S5: reset asserted during beat 3 of requester 2 ----
        req_valid = 4'b0100;
        req_data  = {8'h00, 8'h5A, 8'h00, 8'h00};
        smp(); chk_out("s5 idle", 0, 0, 0, 8'h00, 4'b0000); cyc();
        smp(); chk_out("s5 b1",   1, 2, 1, 8'h5A, 4'b0100); cyc();
        smp(); chk_out("s5 b2",   1, 2, 1, 8'h5A, 4'b0100); cyc();
        smp(); chk_out("s5 b3",   1, 2, 1, 8'h5A, 4'b0100);
        #1;
        arst_n = 1'b0;
        #1;
        chk_out("s5 inrst", 0, 0, 0, 8'h00, 4'b0000);
        req_valid = 4'b1111;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        cyc();
        arst_n = 1'b1;
        smp(); chk_out("s5 post", 0, 0, 0, 8'h00, 4'b0000); cyc();
        smp(); chk_out("s5 g0",   1, 0, 1, 8'h10, 4'b0001); cyc();
        req_valid = '0;
        smp(); chk_out("s5 drop", 1, 0, 0, 8'h10, 4'b0001); cyc();
        smp(); chk_out("s5 end",  0, 0, 0, 8'h00, 4'b0000); cyc();

        // ---- S6: lone requester 3, 10 beats, no last ----
        req_valid = 4'b1000;
        req_last  = '0;
        req_data  = '0;
        wr_cnt    = 0;
        for (int k = 0; k < 15; k++) begin
            logic exp_wr;
            logic exp_gv;
            if (k == 13)
                req_valid = '0;
            req_data[31:24] = 8'(8'h30 + k);
            exp_wr = (k >= 1 && k <= 4) || (k >= 6 && k <= 9) || (k == 11) || (k == 12);
            exp_gv = exp_wr || (k == 13);
            smp();
            if (fifo_wr)
                wr_cnt++;
            chk_out($sformatf("s6 k=%0d", k), exp_gv, exp_gv ? 2'd3 : 2'd0, exp_wr,
                    exp_gv ? 8'(8'h30 + k) : 8'h00, exp_gv ? 4'b1000 : 4'b0000);
            cyc();
        end
        chk("s6 total_writes", 32'(wr_cnt), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
